// File: rtl/data_mem.sv
// Block-organised backing memory for the direct-mapped write-back data cache.
// Every request completes in one cycle: a whole-block write commits at the
// edge, a whole-block read returns the addressed block on out1 and the
// sequentially next block on out2 one cycle later (read-before-write).
// A two-state flush control raises flush_done while flush is held.
module data_mem #(
  parameter int    WORD_SIZE    = 32,
  parameter int    BLOCK_SIZE   = 256,
  parameter int    DEPTH_BLOCKS = 64,
  parameter string INIT_FILE    = ""
`ifdef DATAMEM_DUMP_EN
  ,
  parameter string DUMP_FILE    = "datamem_dump.hex"
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  in,
  input  logic                  readable,
  input  logic                  writable,
  input  logic [BLOCK_SIZE-1:0] write,
  output logic [BLOCK_SIZE-1:0] out1,
  output logic [BLOCK_SIZE-1:0] out2,
  input  logic                  flush,
  output logic                  flush_done
);

  localparam int IDX_W  = $clog2(DEPTH_BLOCKS);
  localparam int OFFS_W = 5;

  typedef enum logic {IDLE, DONE} flush_state_t;

  logic [BLOCK_SIZE-1:0] mem [DEPTH_BLOCKS];
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  flush_state_t          state;
  flush_state_t          state_nxt;

  // Byte offset and address bits above the index do not select a block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in[OFFS_W-1:0], in[WORD_SIZE-1:OFFS_W+IDX_W]};

  // Index wraps modulo DEPTH_BLOCKS by truncation; next block wraps the same way.
  assign idx      = in[OFFS_W +: IDX_W];
  assign idx_next = idx + 1'b1;

  // Power-on contents: zero.
  initial begin
    for (int i = 0; i < DEPTH_BLOCKS; i++) mem[i] = '0;
  end

  // Block write; requests arriving with reset are dropped.
  // NOTE: the storage array is deliberately not reset -- reset must leave
  // memory contents intact, and a reset term would also block RAM inference.
  always_ff @(posedge clk) begin
    if (!rst && writable) mem[idx] <= write;
  end

  // Registered read of the addressed and next block; holds when idle.
  // NOTE: non-blocking reads here sample mem before this edge's write lands,
  // which is exactly the read-before-write behaviour on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1 <= '0;
      out2 <= '0;
    end else if (readable) begin
      out1 <= mem[idx];
      out2 <= mem[idx_next];
    end
  end

  // Flush control state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush next-state: enter DONE on flush, leave when flush drops.
  // NOTE: state_nxt is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush)  state_nxt = DONE;
      DONE:    if (!flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // flush_done is a decode of the registered state, so it changes only at edges.
  assign flush_done = (state == DONE);

endmodule

// File: tb/tb_data_mem.sv
// Directed testbench for data_mem: a table of single-cycle vectors with
// hand-computed expected outputs, followed by hand-written flush sequences.
module tb_data_mem;

  localparam int WS = 32;
  localparam int BS = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] in;
  logic          readable;
  logic          writable;
  logic [BS-1:0] write;
  logic [BS-1:0] out1;
  logic [BS-1:0] out2;
  logic          flush;
  logic          flush_done;

  int n_vec  = 0;
  int n_miss = 0;

  data_mem #(
    .WORD_SIZE   (WS),
    .BLOCK_SIZE  (BS),
    .DEPTH_BLOCKS(64),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .readable  (readable),
    .writable  (writable),
    .write     (write),
    .out1      (out1),
    .out2      (out2),
    .flush     (flush),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [WS-1:0] addr;
    logic          rd;
    logic          wr;
    logic [BS-1:0] wdata;
    logic [BS-1:0] exp1;
    logic [BS-1:0] exp2;
  } vec_t;

  localparam logic [BS-1:0] A = {2{128'h00112233445566778899AABBCCDDEEFF}};
  localparam logic [BS-1:0] B = {8{32'hDEADBEEF}};
  localparam logic [BS-1:0] C = {8{32'h0BADF00D}};
  localparam logic [BS-1:0] D = {8{32'h13579BDF}};
  localparam logic [BS-1:0] Z = '0;

  vec_t vecs[18];

  task automatic check(input string name, input logic [BS-1:0] got, input logic [BS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [WS-1:0] a, input logic rd,
                              input logic wr, input logic [BS-1:0] wd,
                              input logic [BS-1:0] e1, input logic [BS-1:0] e2);
    vec_t v;
    v.rst = r; v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic [WS-1:0] a, input logic rd,
                       input logic wr, input logic [BS-1:0] wd, input logic fl);
    @(negedge clk);
    rst = r; in = a; readable = rd; writable = wr; write = wd; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in = '0; readable = 1'b0; writable = 1'b0; write = '0; flush = 1'b0;

    //               rst  addr           rd  wr  wdata  out1 out2
    vecs[0]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, Z, Z, Z);  // reset
    vecs[1]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, Z, Z, Z);  // read zeroed mem
    vecs[2]  = mk(1'b0, 32'h0000_0040, 1'b0, 1'b1, A, Z, Z);  // mem[2]=A, outputs hold
    vecs[3]  = mk(1'b0, 32'h0000_0060, 1'b0, 1'b1, B, Z, Z);  // mem[3]=B
    vecs[4]  = mk(1'b0, 32'h0000_005F, 1'b1, 1'b0, Z, A, B);  // offset ignored, out2=mem[3]
    vecs[5]  = mk(1'b0, 32'h0000_0080, 1'b1, 1'b1, C, Z, Z);  // read-before-write mem[4]
    vecs[6]  = mk(1'b0, 32'h0000_0080, 1'b1, 1'b0, Z, C, Z);  // new data visible
    vecs[7]  = mk(1'b0, 32'h0000_07E0, 1'b0, 1'b1, D, C, Z);  // mem[63]=D, hold
    vecs[8]  = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, B, C, Z);  // mem[0]=B, hold
    vecs[9]  = mk(1'b0, 32'h0000_07E0, 1'b1, 1'b0, Z, D, B);  // out2 wraps to mem[0]
    vecs[10] = mk(1'b0, 32'h0000_0800, 1'b1, 1'b0, Z, B, Z);  // index 64 wraps to 0
    vecs[11] = mk(1'b0, 32'h0000_0020, 1'b0, 1'b1, A, B, Z);  // write-back mem[1]=A
    vecs[12] = mk(1'b0, 32'h0000_0060, 1'b1, 1'b0, Z, B, C);  // fill right after
    vecs[13] = mk(1'b0, 32'h0000_0020, 1'b1, 1'b0, Z, A, A);  // mem[1] updated
    vecs[14] = mk(1'b0, 32'hFFFF_F840, 1'b1, 1'b0, Z, A, B);  // upper bits ignored
    vecs[15] = mk(1'b1, 32'h0000_0000, 1'b1, 1'b1, C, Z, Z);  // reset drops read+write
    vecs[16] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, Z, B, A);  // mem[0] unchanged
    vecs[17] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, B, A);  // idle holds

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].rst, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, 1'b0);
      check($sformatf("vec%0d out1", i), out1, vecs[i].exp1);
      check($sformatf("vec%0d out2", i), out2, vecs[i].exp2);
      if (i == 0) check("reset flush_done", {255'b0, flush_done}, Z);
    end

    // Flush held three cycles with a same-cycle write to mem[2]; read in DONE.
    @(negedge clk);
    rst = 1'b0; readable = 1'b0; writable = 1'b0; flush = 1'b1;
    #1 check("flush c1 before edge", {255'b0, flush_done}, Z);
    cycle(1'b0, 32'h0000_0040, 1'b0, 1'b1, D, 1'b1);
    check("flush c2", {255'b0, flush_done}, {255'b0, 1'b1});
    cycle(1'b0, 32'h0000_0040, 1'b1, 1'b0, Z, 1'b1);
    check("flush c3", {255'b0, flush_done}, {255'b0, 1'b1});
    check("read in DONE out1", out1, D);
    check("read in DONE out2", out2, B);
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b1);
    check("flush held", {255'b0, flush_done}, {255'b0, 1'b1});
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b0);
    check("flush released", {255'b0, flush_done}, Z);

    // Reset while in DONE returns to IDLE; flush still high re-enters DONE.
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b1);
    check("re-flush", {255'b0, flush_done}, {255'b0, 1'b1});
    cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b1);
    check("reset in DONE", {255'b0, flush_done}, Z);
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b1);
    check("flush after reset", {255'b0, flush_done}, {255'b0, 1'b1});
    cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0, Z, 1'b0);
    check("final release", {255'b0, flush_done}, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
